data_mat: RTL and testbench

- 4x4 byte state matrix (128 bits) for the AES-128 datapath.
- Provides a 32-bit write and a 32-bit read of any single row or column, selected by index.
- Sits between the round-function units (SubBytes, ShiftRows, MixColumns, AddRoundKey) and the load/unload logic.
- Column access serves MixColumns and AddRoundKey; row access serves ShiftRows.

---
 rtl/data_mat_if.sv | 14 +
 rtl/data_mat.sv | 56 +++++
 tb/tb_data_mat.sv | 137 +++++++++++++
 3 files changed

// File: rtl/data_mat_if.sv
// Access port of the AES state matrix: select a row/column, then read it or write it.
interface data_mat_if;
    logic [31:0] col_in;
    logic [1:0]  idx;
    logic        row_col;
    logic        read_write;
    logic        write_enable;
    logic [31:0] out;

    // Requester drives the select/data lines every cycle; no handshake, a write
    // commits on the rising edge where read_write and write_enable are both 1.
    modport master (output col_in, idx, row_col, read_write, write_enable, input out);
    modport slave  (input col_in, idx, row_col, read_write, write_enable, output out);
endinterface

// File: rtl/data_mat.sv
// 4x4 byte AES state matrix with single row/column word write and combinational read.
// Byte 0 of a word (bits 31:24) is row 0 of a column, or column 0 of a row.
module data_mat (
    input  logic        clk,
    input  logic        rst,
    data_mat_if.slave   bus
);
    // m_q[r][c]: row r, column c
    logic [3:0][3:0][7:0] m_q, m_d;
    logic [31:0]          last_read_q, last_read_d;
    logic [31:0]          sel_word;
    logic                 wr_en;

    assign wr_en = bus.read_write & bus.write_enable;

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (bus.row_col)
                sel_word[31-8*k -: 8] = m_q[k][bus.idx];
            else
                sel_word[31-8*k -: 8] = m_q[bus.idx][k];
        end
    end

    always_comb begin
        m_d = m_q;
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.row_col)
                    m_d[k][bus.idx] = bus.col_in[31-8*k -: 8];
                else
                    m_d[bus.idx][k] = bus.col_in[31-8*k -: 8];
            end
        end
    end

    // Reads refresh the hold register so a following write cycle shows the last read word
    always_comb begin
        last_read_d = last_read_q;
        if (!bus.read_write)
            last_read_d = sel_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q         <= '0;
            last_read_q <= '0;
        end else begin
            m_q         <= m_d;
            last_read_q <= last_read_d;
        end
    end

    assign bus.out = bus.read_write ? last_read_q : sel_word;
endmodule

// File: tb/tb_data_mat.sv
// Directed bench for data_mat: driver issues row/column operations, monitor checks out at negedge.
module tb_data_mat;
    logic clk;
    logic rst;
    data_mat_if bus ();

    data_mat dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        chk_v;
    int          n_cmp;
    int          n_bad;

    // Monitor: one pop per cycle in which the driver flagged a check
    always @(negedge clk) begin
        if (chk_v) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL monitor_underflow: out=%h, no expected value queued", bus.out);
            end else begin
                logic [31:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (bus.out !== e) begin
                    n_bad++;
                    $display("FAIL %s: out=%h expected=%h", nm, bus.out, e);
                end
            end
        end
    end

    task automatic set_bus(input logic rw, input logic we, input logic rc,
                           input logic [1:0] ix, input logic [31:0] d);
        bus.read_write   = rw;
        bus.write_enable = we;
        bus.row_col      = rc;
        bus.idx          = ix;
        bus.col_in       = d;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk_v = 1'b1;
    endtask

    // One operation per clock: driven just after posedge, held through the next posedge
    task automatic op(input string nm, input logic rw, input logic we, input logic rc,
                      input logic [1:0] ix, input logic [31:0] d,
                      input logic chk, input logic [31:0] e);
        @(posedge clk);
        #1;
        chk_v = 1'b0;
        set_bus(rw, we, rc, ix, d);
        if (chk) expect_out(nm, e);
    endtask

    task automatic rd(input string nm, input logic rc, input logic [1:0] ix, input logic [31:0] e);
        op(nm, 1'b0, 1'b0, rc, ix, 32'h0, 1'b1, e);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        chk_v = 1'b0;
        rst   = 1'b1;
        set_bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state: writing side shows cleared hold register, gated write changes nothing
        op("rst_out_writing", 1'b1, 1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) rd($sformatf("rst_col%0d", i), 1'b1, 2'(i), 32'h0);
        for (int i = 0; i < 4; i++) rd($sformatf("rst_row%0d", i), 1'b0, 2'(i), 32'h0);

        // Column 0 write; out during write holds last read (row 3 = 0)
        op("wr_col0_hold", 1'b1, 1'b1, 1'b1, 2'd0, 32'h1122_3344, 1'b1, 32'h0);
        rd("col0_after_wr", 1'b1, 2'd0, 32'h1122_3344);
        rd("row1_after_col0", 1'b0, 2'd1, 32'h2200_0000);

        // Row 2 write overlaps column 0 at m[2][0]
        op("wr_row2_hold", 1'b1, 1'b1, 1'b0, 2'd2, 32'h5566_7788, 1'b1, 32'h2200_0000);
        rd("row2_after_wr", 1'b0, 2'd2, 32'h5566_7788);
        rd("col0_overlap", 1'b1, 2'd0, 32'h1122_5544);

        // Column 3 write overlaps row 2 at m[2][3]
        op("wr_col3_hold", 1'b1, 1'b1, 1'b1, 2'd3, 32'h99AA_BBCC, 1'b1, 32'h1122_5544);
        rd("col3_after_wr", 1'b1, 2'd3, 32'h99AA_BBCC);
        rd("row2_overlap", 1'b0, 2'd2, 32'h5566_77BB);
        rd("row0_mixed", 1'b0, 2'd0, 32'h1100_0099);
        rd("col3_pre_gate", 1'b1, 2'd3, 32'h99AA_BBCC);

        // Gated write: out shows last read, matrix untouched
        op("gated_wr_hold", 1'b1, 1'b0, 1'b1, 2'd3, 32'hDEAD_BEEF, 1'b1, 32'h99AA_BBCC);
        rd("col3_after_gate", 1'b1, 2'd3, 32'h99AA_BBCC);

        // Read with write_enable high must not write
        op("rd_we_ignored", 1'b0, 1'b1, 1'b1, 2'd1, 32'hDEAD_BEEF, 1'b1, 32'h0000_6600);
        rd("col1_after_rdwe", 1'b1, 2'd1, 32'h0000_6600);

        // Async reset pulse between edges with a write pending
        op("pend_wr", 1'b1, 1'b1, 1'b1, 2'd1, 32'hCAFE_F00D, 1'b0, 32'h0);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        set_bus(1'b0, 1'b0, 1'b1, 2'd1, 32'h0);
        expect_out("async_rst_col1", 32'h0);
        rd("async_rst_col3", 1'b1, 2'd3, 32'h0);
        rd("async_rst_row2", 1'b0, 2'd2, 32'h0);

        // Reset held across an edge wins over a coincident write
        op("wr_col2_rst", 1'b1, 1'b1, 1'b1, 2'd2, 32'h1234_5678, 1'b0, 32'h0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_v = 1'b0;
        set_bus(1'b1, 1'b0, 1'b1, 2'd2, 32'h0);
        expect_out("rst_wins_hold", 32'h0);
        rd("rst_wins_col2", 1'b1, 2'd2, 32'h0);

        op("idle", 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
